// File: rtl/id_stage_pipe.sv
// Pipelined rv32 instruction-decode stage: register file, immediate generation, ID/EX output register.
// Optional macro ID_BYPASS_EN: same-edge write-back data is forwarded into the captured operands.
module id_stage_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              instruction,
   input  logic                     flush,
   input  logic                     wb_en,
   input  logic [$clog2(NREGS)-1:0] wb_rd,
   input  logic [XLEN-1:0]          wb_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [6:0]               opcode,
   output logic [2:0]               func3,
   output logic [6:0]               func7,
   output logic [4:0]               rd,
   output logic [XLEN-1:0]          r1,
   output logic [XLEN-1:0]          r2,
   output logic [XLEN-1:0]          immediate,
   output logic                     reg_write,
   output logic                     illegal
);

   localparam int unsigned AW = $clog2(NREGS);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [XLEN-1:0] regs_q [NREGS];

   logic            out_valid_q, out_valid_d;
   logic [6:0]      opcode_q, func7_q;
   logic [2:0]      func3_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] r1_q, r2_q, imm_q;
   logic            reg_write_q, illegal_q;

   logic [XLEN-1:0] r1_d, r2_d, imm_d;
   logic            reg_write_d, illegal_d;
   logic [31:0]     imm32;
   logic            writes_rd, legal_op, use_rs1, use_rs2, use_rd;
   logic [4:0]      rs1_f, rs2_f, rd_f;
   logic            rs1_ok, rs2_ok, rd_ok;
   logic            capture;

   assign rs1_f = instruction[19:15];
   assign rs2_f = instruction[24:20];
   assign rd_f  = instruction[11:7];
   assign rs1_ok = ({27'b0, rs1_f} < NREGS);
   assign rs2_ok = ({27'b0, rs2_f} < NREGS);
   assign rd_ok  = ({27'b0, rd_f}  < NREGS);

   assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);
   assign capture  = in_valid && in_ready;

   always_comb begin
      imm32     = '0;
      writes_rd = 1'b0;
      legal_op  = 1'b1;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      use_rd    = 1'b0;
      unique case (instruction[6:0])
         OP_R: begin
            writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            imm32     = {{20{instruction[31]}}, instruction[31:20]};
            writes_rd = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
         end
         OP_STORE: begin
            imm32   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_BRANCH: begin
            imm32   = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                       instruction[11:8], 1'b0};
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            imm32     = {instruction[31:12], 12'b0};
            writes_rd = 1'b1; use_rd = 1'b1;
         end
         OP_JAL: begin
            imm32     = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                         instruction[30:21], 1'b0};
            writes_rd = 1'b1; use_rd = 1'b1;
         end
         OP_FENCE, OP_SYSTEM: begin
            use_rs1 = 1'b1; use_rd = 1'b1;
         end
         default: legal_op = 1'b0;
      endcase
      illegal_d   = !legal_op || (use_rs1 && !rs1_ok) || (use_rs2 && !rs2_ok)
                    || (use_rd && !rd_ok);
      reg_write_d = writes_rd && (rd_f != 5'd0) && !illegal_d;
      imm_d       = XLEN'($signed(imm32));
   end

   // Out-of-range indices read as zero; the instruction is flagged illegal anyway.
   always_comb begin
      r1_d = '0;
      r2_d = '0;
      if (rs1_f != 5'd0 && rs1_ok) r1_d = regs_q[rs1_f[AW-1:0]];
      if (rs2_f != 5'd0 && rs2_ok) r2_d = regs_q[rs2_f[AW-1:0]];
`ifdef ID_BYPASS_EN
      if (wb_en && rs1_f != 5'd0 && rs1_ok && wb_rd == rs1_f[AW-1:0]) r1_d = wb_data;
      if (wb_en && rs2_f != 5'd0 && rs2_ok && wb_rd == rs2_f[AW-1:0]) r2_d = wb_data;
`endif
   end

   always_comb begin
      out_valid_d = out_valid_q;
      if (flush)          out_valid_d = 1'b0;
      else if (capture)   out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         opcode_q    <= '0;
         func3_q     <= '0;
         func7_q     <= '0;
         rd_q        <= '0;
         r1_q        <= '0;
         r2_q        <= '0;
         imm_q       <= '0;
         reg_write_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         if (capture) begin
            opcode_q    <= instruction[6:0];
            func3_q     <= instruction[14:12];
            func7_q     <= instruction[31:25];
            rd_q        <= rd_f;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            imm_q       <= imm_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wb_en && wb_rd != '0) begin
         regs_q[wb_rd] <= wb_data;
      end
   end

   assign out_valid = out_valid_q;
   assign opcode    = opcode_q;
   assign func3     = func3_q;
   assign func7     = func7_q;
   assign rd        = rd_q;
   assign r1        = r1_q;
   assign r2        = r2_q;
   assign immediate = imm_q;
   assign reg_write = reg_write_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: spec-level decode model, per-cycle compare, handshake scoreboard,
// plus literal expectations; a second RV32E instance checks the 16-register variant.
module tb_id_stage_pipe;

`ifdef ID_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, wb_en, out_ready;
   logic [31:0] instruction, wb_data;
   logic [4:0]  wb_rd;

   logic        in_ready, out_valid, reg_write, illegal;
   logic [6:0]  opcode, func7;
   logic [2:0]  func3;
   logic [4:0]  rd;
   logic [31:0] r1, r2, immediate;

   logic        e_in_ready, e_out_valid, e_reg_write, e_illegal;
   logic [6:0]  e_opcode, e_func7;
   logic [2:0]  e_func3;
   logic [4:0]  e_rd;
   logic [31:0] e_r1, e_r2, e_immediate;
   logic        e_wb_en;
   logic [3:0]  e_wb_rd;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign e_wb_en = wb_en && !wb_rd[4];
   assign e_wb_rd = wb_rd[3:0];

   id_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .func3(func3), .func7(func7), .rd(rd), .r1(r1), .r2(r2),
      .immediate(immediate), .reg_write(reg_write), .illegal(illegal)
   );

   id_stage_pipe #(.XLEN(32), .NREGS(16)) dut_e (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready),
      .instruction(instruction), .flush(flush), .wb_en(e_wb_en), .wb_rd(e_wb_rd),
      .wb_data(wb_data), .out_valid(e_out_valid), .out_ready(out_ready),
      .opcode(e_opcode), .func3(e_func3), .func7(e_func7), .rd(e_rd), .r1(e_r1), .r2(e_r2),
      .immediate(e_immediate), .reg_write(e_reg_write), .illegal(e_illegal)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model (32-register, XLEN=32) ----------------
   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [31:0] r1, r2, imm;
      logic        rw, ill;
   } dec_t;

   logic [31:0] mregs [32];
   dec_t        ef = '0;
   logic        ev = 1'b0;
   logic        started = 1'b0;

   function automatic logic [31:0] rdreg(input logic [4:0] idx, input logic wbe,
                                         input logic [4:0] wrd, input logic [31:0] wd);
      if (idx == 0) return 32'h0;
      if (BYP && wbe && wrd == idx) return wd;
      return mregs[idx];
   endfunction

   function automatic dec_t decode(input logic [31:0] in, input logic wbe,
                                   input logic [4:0] wrd, input logic [31:0] wd);
      dec_t d;
      int   simm;
      bit   wr;
      d     = '0;
      d.op  = in[6:0];
      d.f3  = in[14:12];
      d.f7  = in[31:25];
      d.rd  = in[11:7];
      d.r1  = rdreg(in[19:15], wbe, wrd, wd);
      d.r2  = rdreg(in[24:20], wbe, wrd, wd);
      simm  = 0;
      wr    = 0;
      case (d.op)
         7'h33: wr = 1;
         7'h13, 7'h03, 7'h67: begin simm = int'($signed(in[31:20])); wr = 1; end
         7'h23: simm = int'($signed({in[31:25], in[11:7]}));
         7'h63: simm = int'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
         7'h37, 7'h17: begin simm = int'({in[31:12], 12'h000}); wr = 1; end
         7'h6F: begin simm = int'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0})); wr = 1; end
         7'h0F, 7'h73: ;
         default: d.ill = 1'b1;
      endcase
      d.imm = 32'(simm);
      d.rw  = wr && (d.rd != 0) && !d.ill;
      return d;
   endfunction

   always @(posedge clk) begin
      bit take;
      if (!rst_n) begin
         ev = 1'b0;
         ef = '0;
         for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
         started = 1'b1;
      end else begin
         take = in_valid && !flush && (!ev || out_ready);
         if (take) ef = decode(instruction, wb_en, wb_rd, wb_data);
         if (flush)          ev = 1'b0;
         else if (take)      ev = 1'b1;
         else if (out_ready) ev = 1'b0;
         if (wb_en && wb_rd != 0) mregs[wb_rd] = wb_data;
      end
   end

   // ---------------- per-cycle compare and handshake scoreboard ----------------
   logic [31:0] sb_q [$];

   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", in_ready, rst_n && !flush && (!ev || out_ready));
         chk("out_valid", out_valid, ev);
         chk("opcode", opcode, ef.op);
         chk("func3", func3, ef.f3);
         chk("func7", func7, ef.f7);
         chk("rd", rd, ef.rd);
         chk("r1", r1, ef.r1);
         chk("r2", r2, ef.r2);
         chk("immediate", immediate, ef.imm);
         chk("reg_write", reg_write, ef.rw);
         chk("illegal", illegal, ef.ill);
         if (!rst_n) begin
            sb_q.delete();
         end else begin
            if (out_valid && (flush || out_ready)) begin
               if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
               else begin
                  if (!flush) chk("sb_order_imm", immediate, sb_q[0]);
                  void'(sb_q.pop_front());
               end
            end
            if (in_valid && in_ready) sb_q.push_back(decode(instruction, 1'b0, 5'd0, 32'h0).imm);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input logic v, input logic [31:0] ins, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd,
                      input logic fl, input logic rdy);
      in_valid = v; instruction = ins; wb_en = we; wb_rd = wr; wb_data = wd;
      flush = fl; out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] I_ADDI  = 32'hFFF28313; // addi x6,x5,-1
   localparam logic [31:0] I_SW    = 32'hFE712C23; // sw x7,-8(x2)
   localparam logic [31:0] I_BEQ   = 32'h80000063; // beq x0,x0,-4096
   localparam logic [31:0] I_JAL   = 32'h002000EF; // jal x1,+2
   localparam logic [31:0] I_ADD3  = 32'h000180B3; // add x1,x3,x0
   localparam logic [31:0] I_ADD9  = 32'h000480B3; // add x1,x9,x0
   localparam logic [31:0] I_ADD0  = 32'h000000B3; // add x1,x0,x0
   localparam logic [31:0] I_ADD20 = 32'h00208A33; // add x20,x1,x2

   function automatic logic [31:0] addi_x1(input int k);
      return (32'(k) << 20) | 32'h0000_0093;
   endfunction

   initial begin
      rst_n = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 5, 32'h0000_0055, 0, 1);
      chk("lit_ready_in_reset", in_ready, 0);
      chk("lit_valid_in_reset", out_valid, 0);
      rst_n = 1'b1;
      #1;
      chk("lit_ready_after_reset", in_ready, 1);
      chk("lit_e_valid_reset", e_out_valid, 0);

      cyc(0, 0, 1, 5, 32'h0000_1234, 0, 1);
      cyc(0, 0, 1, 3, 32'h1111_0000, 0, 1);
      cyc(1, I_ADDI, 0, 0, 0, 0, 1);
      chk("lit_addi_valid", out_valid, 1);
      chk("lit_addi_r1", r1, 32'h0000_1234);
      chk("lit_addi_imm", immediate, 32'hFFFF_FFFF);
      chk("lit_addi_rw", reg_write, 1);
      chk("lit_addi_ill", illegal, 0);
      chk("lit_addi_rd", rd, 6);
      chk("lit_e_addi_r1", e_r1, 32'h0000_1234);
      cyc(1, I_SW, 0, 0, 0, 0, 1);
      chk("lit_sw_imm", immediate, 32'hFFFF_FFF8);
      chk("lit_sw_rw", reg_write, 0);
      cyc(1, I_BEQ, 0, 0, 0, 0, 1);
      chk("lit_beq_imm", immediate, 32'hFFFF_F000);
      cyc(1, I_JAL, 0, 0, 0, 0, 1);
      chk("lit_jal_imm", immediate, 32'h0000_0002);
      chk("lit_jal_rw", reg_write, 1);

      cyc(1, I_ADD3, 1, 3, 32'hDEAD_BEEF, 0, 1);
      chk("lit_bypass_r1", r1, BYP ? 32'hDEAD_BEEF : 32'h1111_0000);
      cyc(1, I_ADD3, 0, 0, 0, 0, 1);
      chk("lit_after_wb_r1", r1, 32'hDEAD_BEEF);

      for (int k = 0; k < 3; k++) begin
         cyc(1, addi_x1(1), 0, 0, 0, 0, 0);
         chk("lit_stall_ready", in_ready, 0);
         chk("lit_stall_r1", r1, 32'hDEAD_BEEF);
      end
      for (int k = 1; k <= 3; k++) begin
         cyc(1, addi_x1(k), 0, 0, 0, 0, 1);
         chk("lit_stream_imm", immediate, 32'(k));
      end
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("lit_drain_valid", out_valid, 0);

      cyc(1, addi_x1(4), 0, 0, 0, 0, 0);
      cyc(1, addi_x1(5), 1, 9, 32'hCAFE_0009, 1, 1);
      chk("lit_flush_valid", out_valid, 0);
      chk("lit_flush_not_taken", immediate, 32'h4);
      cyc(1, I_ADD9, 0, 0, 0, 0, 1);
      chk("lit_flush_wb_lands", r1, 32'hCAFE_0009);

      cyc(1, 32'h0000_007F, 0, 0, 0, 0, 1);
      chk("lit_ill_op", illegal, 1);
      chk("lit_ill_rw", reg_write, 0);
      chk("lit_e_ill_op", e_illegal, 1);
      cyc(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 1);
      cyc(1, I_ADD0, 0, 0, 0, 0, 1);
      chk("lit_x0_r1", r1, 0);
      chk("lit_e_x0_r1", e_r1, 0);
      cyc(1, I_ADD20, 0, 0, 0, 0, 1);
      chk("lit_add20_ill", illegal, 0);
      chk("lit_add20_rw", reg_write, 1);
      chk("lit_e_add20_ill", e_illegal, 1);
      chk("lit_e_add20_rw", e_reg_write, 0);

      cyc(1, addi_x1(6), 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      cyc(0, 0, 1, 9, 32'h5555_5555, 0, 0);
      chk("lit_midrst_valid", out_valid, 0);
      chk("lit_midrst_op", opcode, 0);
      rst_n = 1'b1;
      cyc(1, I_ADD9, 0, 0, 0, 0, 1);
      chk("lit_midrst_x9", r1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised, pipelined instruction-decode stage for the rv32 core. It decodes one instruction per accepted handshake, reads a configurable integer register file with write-back forwarding, and generates format-correct sign-extended immediates. Results land in a registered ID/EX output stage with valid/ready flow control and flush. It sits between the fetch stage and the execute stage and owns the architectural register file.

## Interface
Parameters:
- XLEN, 32 — datapath width; legal values 32 or 64.
- NREGS, 32 — number of integer registers; legal values 32 (RV32I) or 16 (RV32E).

Ports:
- clk  in  1  — single clock; all state updates on rising edge.
- rst_n  in  1  — reset; synchronous, active-low.
- in_valid  in  1  — instruction valid from fetch.
- in_ready  out  1  — stage can accept; equals !out_valid || out_ready, forced 0 while flush=1.
- instruction  in  32  — raw instruction word.
- flush  in  1  — kill the held output and refuse input this cycle.
- wb_en  in  1  — register write enable from write-back.
- wb_rd  in  $clog2(NREGS)  — write-back destination index.
- wb_data  in  XLEN  — write-back data.
- out_valid  out  1  — ID/EX register holds a decoded instruction.
- out_ready  in  1  — execute accepts.
- opcode  out  7; func3  out  3; func7  out  7; rd  out  5 — decoded fields.
- r1, r2  out  XLEN  — source operand values.
- immediate  out  XLEN  — sign-extended immediate.
- reg_write  out  1  — instruction writes rd (rd != 0).
- illegal  out  1  — unsupported opcode or register index >= NREGS.

## Operation
- Capture when in_valid && in_ready: all output fields registered, out_valid <= 1.
- Hold: out_valid && !out_ready keeps every output stable.
- Drain: out_ready && no capture -> out_valid <= 0.
- Flush: out_valid <= 0 next edge; no capture that cycle; register-file write still occurs.
- Register file: NREGS x XLEN; x0 reads 0, writes to x0 ignored; write when wb_en=1 at clock edge, independent of handshake.
- Immediates, sign-extended from bit 31 to XLEN:
  - I (0010011, 0000011, 1100111): inst[31:20].
  - S (0100011): {inst[31:25], inst[11:7]}.
  - B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U (0110111, 0010111): {inst[31:12], 12'b0}.
  - J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All others: 0.
- reg_write = 1 for R (0110011), I-ALU, load, JAL, JALR, LUI, AUIPC with rd != 0; else 0.
- illegal = 1 for any opcode outside the above plus 0100011, 1100011, 0001111, 1110011; also when NREGS=16 and any used rs1/rs2/rd field >= 16. Illegal instructions still propagate with reg_write = 0.

## Timing
- Latency: 1 cycle, capture edge -> out_valid.
- Throughput: 1 instruction per cycle while out_ready=1.
- Reset (rst_n=0 at edge): out_valid, opcode, func3, func7, rd, r1, r2, immediate, reg_write, illegal all 0; all registers 0. in_ready = 0 during reset, 1 the cycle after.
- Reset mid-operation discards the held instruction; no write-back occurs on the reset edge.
- Same-cycle write-back and read of the same non-zero register: see Configuration.
- flush and out_ready together: flush wins; out_valid <= 0.

## Configuration
- ID_BYPASS_EN defined: write-through forwarding; when wb_en && wb_rd == rs && rs != 0 at the capture edge, the captured r1/r2 equals wb_data.
- ID_BYPASS_EN undefined: captured r1/r2 is the pre-write register value; the new value is visible from the next capture.

## Test plan
- Reset, then write x5=0x0000_1234, decode ADDI x6,x5,-1 (0xFFF28313) -> next cycle out_valid=1, r1=0x1234, immediate=0xFFFF_FFFF, reg_write=1, illegal=0.
- Decode SW x7,-8(x2) (0xFE712C23) -> immediate=0xFFFF_FFF8, reg_write=0; BEQ offset -4096 -> immediate=0xFFFF_F000; JAL +2 -> immediate=0x2.
- Same-cycle wb_en=1, wb_rd=3, wb_data=0xDEAD_BEEF with ADD x1,x3,x0 captured -> r1=0xDEADBEEF with ID_BYPASS_EN, old x3 without it.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> one instruction per cycle, none lost or duplicated.
- flush=1 while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not taken; concurrent wb_en write still lands.
- NREGS=16: decode ADD x20,x1,x2 -> illegal=1, reg_write=0; opcode 0x7F -> illegal=1; write to x0 then read -> 0.
